// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-note score accumulator, health tracker and song FSM (optional max combo: SCORE_MAX_COMBO_EN)
module score_accumulator #(
   parameter int W       = 32,
   parameter int HP_MAX  = 100,
   parameter int HP_GAIN = 2,
   parameter int HP_LOSS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [1:0]   mod,
   input  logic [W-1:0] total_note,
   input  logic         hit_valid,
   input  logic [W-1:0] base_score,
   input  logic [W-1:0] bonus_score,
   input  logic [W-1:0] combo,
   output logic         hit_ready,
   output logic [W-1:0] last_combo,
   output logic [W-1:0] last_base_score,
   output logic [W-1:0] now_cnt,
   output logic [W-1:0] total_score,
   output logic [W-1:0] max_combo,
   output logic [7:0]   hp,
   output logic         failed,
   output logic         done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_FAILED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] MOD_NO_FAIL = 2'b01;

   state_t       state_q, state_d;
   logic [W-1:0] total_note_q, total_note_d;
   logic [1:0]   mod_q, mod_d;
   logic [W-1:0] last_combo_q, last_combo_d;
   logic [W-1:0] last_base_q, last_base_d;
   logic [W-1:0] now_cnt_q, now_cnt_d;
   logic [W-1:0] total_score_q, total_score_d;
   logic [7:0]   hp_q, hp_d;

   logic         accept;
   logic [W:0]   base_sum;
   logic [W-1:0] base_sat;
   logic [W+1:0] total_sum;
   logic [W-1:0] total_sat;
   logic [8:0]   hp_gain_sum;
   logic [7:0]   hp_after_hit;
   logic [7:0]   hp_after_miss;
   logic [7:0]   hp_note;
   logic [W-1:0] cnt_inc;

   // Saturating datapath for one accepted note; sums carry extra bits then clamp to all-ones.
   always_comb begin
      accept        = (state_q == S_PLAY) && hit_valid;
      base_sum      = {1'b0, last_base_q} + {1'b0, base_score};
      base_sat      = base_sum[W] ? {W{1'b1}} : base_sum[W-1:0];
      total_sum     = {2'b00, total_score_q} + {2'b00, base_score} + {2'b00, bonus_score};
      total_sat     = (|total_sum[W+1:W]) ? {W{1'b1}} : total_sum[W-1:0];
      hp_gain_sum   = {1'b0, hp_q} + 9'(HP_GAIN);
      hp_after_hit  = (hp_gain_sum > 9'(HP_MAX)) ? 8'(HP_MAX) : hp_gain_sum[7:0];
      hp_after_miss = (hp_q > 8'(HP_LOSS)) ? (hp_q - 8'(HP_LOSS)) : 8'd0;
      hp_note       = (base_score == '0) ? hp_after_miss : hp_after_hit;
      cnt_inc       = now_cnt_q + W'(1);
   end

   // Next-state and register update: abort beats start, start beats a same-cycle note.
   always_comb begin
      state_d       = state_q;
      total_note_d  = total_note_q;
      mod_d         = mod_q;
      last_combo_d  = last_combo_q;
      last_base_d   = last_base_q;
      now_cnt_d     = now_cnt_q;
      total_score_d = total_score_q;
      hp_d          = hp_q;
      if (abort) begin
         state_d = S_IDLE;
      end else if (start) begin
         last_combo_d  = '0;
         last_base_d   = '0;
         now_cnt_d     = '0;
         total_score_d = '0;
         hp_d          = 8'(HP_MAX);
         total_note_d  = total_note;
         mod_d         = mod;
         state_d       = (total_note == '0) ? S_DONE : S_PLAY;
      end else if (accept) begin
         last_combo_d  = combo;
         last_base_d   = base_sat;
         total_score_d = total_sat;
         now_cnt_d     = cnt_inc;
         hp_d          = hp_note;
         if ((hp_note == 8'd0) && (mod_q != MOD_NO_FAIL)) begin
            state_d = S_FAILED;
         end else if (cnt_inc == total_note_q) begin
            state_d = S_DONE;
         end else begin
            state_d = S_PLAY;
         end
      end
   end

   // State and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         total_note_q  <= '0;
         mod_q         <= 2'b00;
         last_combo_q  <= '0;
         last_base_q   <= '0;
         now_cnt_q     <= '0;
         total_score_q <= '0;
         hp_q          <= 8'(HP_MAX);
      end else begin
         state_q       <= state_d;
         total_note_q  <= total_note_d;
         mod_q         <= mod_d;
         last_combo_q  <= last_combo_d;
         last_base_q   <= last_base_d;
         now_cnt_q     <= now_cnt_d;
         total_score_q <= total_score_d;
         hp_q          <= hp_d;
      end
   end

`ifdef SCORE_MAX_COMBO_EN
   logic [W-1:0] max_combo_q, max_combo_d;

   // Highest combo seen this song; cleared with the other totals on start.
   always_comb begin
      max_combo_d = max_combo_q;
      if (abort) begin
         max_combo_d = max_combo_q;
      end else if (start) begin
         max_combo_d = '0;
      end else if (accept && (combo > max_combo_q)) begin
         max_combo_d = combo;
      end
   end

   // Max combo register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_combo_q <= '0;
      end else begin
         max_combo_q <= max_combo_d;
      end
   end

   assign max_combo = max_combo_q;
`else
   assign max_combo = '0;
`endif

   assign hit_ready       = (state_q == S_PLAY);
   assign failed          = (state_q == S_FAILED);
   assign done            = (state_q == S_DONE);
   assign last_combo      = last_combo_q;
   assign last_base_score = last_base_q;
   assign now_cnt         = now_cnt_q;
   assign total_score     = total_score_q;
   assign hp              = hp_q;

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - scoreboard bench for score_accumulator
module tb_score_accumulator;

   localparam int W = 32;
   localparam logic [W-1:0] BIG = 32'hFFFF_FFFE;
   localparam logic [W-1:0] SAT = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [1:0]   mod = 2'b00;
   logic [W-1:0] total_note = '0;
   logic         hit_valid = 1'b0;
   logic [W-1:0] base_score = '0;
   logic [W-1:0] bonus_score = '0;
   logic [W-1:0] combo = '0;
   logic         hit_ready;
   logic [W-1:0] last_combo;
   logic [W-1:0] last_base_score;
   logic [W-1:0] now_cnt;
   logic [W-1:0] total_score;
   logic [W-1:0] max_combo;
   logic [7:0]   hp;
   logic         failed;
   logic         done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] cnt;
      logic [W-1:0] base;
      logic [W-1:0] tot;
      logic [W-1:0] lc;
      logic [7:0]   hp;
      logic         fl;
      logic         dn;
      logic         rdy;
      logic [W-1:0] mc;
      string        tag;
   } exp_t;

   exp_t sb_q[$];

   score_accumulator dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .mod             (mod),
      .total_note      (total_note),
      .hit_valid       (hit_valid),
      .base_score      (base_score),
      .bonus_score     (bonus_score),
      .combo           (combo),
      .hit_ready       (hit_ready),
      .last_combo      (last_combo),
      .last_base_score (last_base_score),
      .now_cnt         (now_cnt),
      .total_score     (total_score),
      .max_combo       (max_combo),
      .hp              (hp),
      .failed          (failed),
      .done            (done)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mcx(input logic [W-1:0] v);
`ifdef SCORE_MAX_COMBO_EN
      return v;
`else
      return (v & '0);
`endif
   endfunction

   task automatic chk(input string tag, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, name, act, act, exp, exp);
      end
   endtask

   // Monitor: outputs are registered, so a pending expectation is compared on each falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.tag, "now_cnt",         now_cnt,              e.cnt);
         chk(e.tag, "last_base_score", last_base_score,      e.base);
         chk(e.tag, "total_score",     total_score,          e.tot);
         chk(e.tag, "last_combo",      last_combo,           e.lc);
         chk(e.tag, "hp",              W'(hp),               W'(e.hp));
         chk(e.tag, "failed",          W'(failed),           W'(e.fl));
         chk(e.tag, "done",            W'(done),             W'(e.dn));
         chk(e.tag, "hit_ready",       W'(hit_ready),        W'(e.rdy));
         chk(e.tag, "max_combo",       max_combo,            e.mc);
      end
   end

   task automatic drive(input logic st, input logic ab, input logic [1:0] md, input logic [W-1:0] tn,
                        input logic hv, input logic [W-1:0] b, input logic [W-1:0] bn, input logic [W-1:0] cb);
      @(negedge clk);
      start = st; abort = ab; mod = md; total_note = tn;
      hit_valid = hv; base_score = b; bonus_score = bn; combo = cb;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0; hit_valid = 1'b0;
      base_score = '0; bonus_score = '0; combo = '0;
   endtask

   task automatic hit(input logic [W-1:0] b, input logic [W-1:0] bn, input logic [W-1:0] cb);
      drive(1'b0, 1'b0, mod, total_note, 1'b1, b, bn, cb);
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] cnt, input logic [W-1:0] base,
                             input logic [W-1:0] tot, input logic [W-1:0] lc, input logic [7:0] h,
                             input logic fl, input logic dn, input logic rdy, input logic [W-1:0] mc);
      exp_t e;
      e.tag = tag; e.cnt = cnt; e.base = base; e.tot = tot; e.lc = lc;
      e.hp = h; e.fl = fl; e.dn = dn; e.rdy = rdy; e.mc = mc;
      sb_q.push_back(e);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      expect_out("reset", 0, 0, 0, 0, 100, 0, 0, 0, 0);

      // 1: three perfect hits, song of 3
      drive(1'b1, 1'b0, 2'b00, 3, 1'b0, 0, 0, 0);
      expect_out("t1_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(1666, 100, 2);
      expect_out("t1_h1", 1, 1666, 1766, 2, 100, 0, 0, 1, mcx(2));
      hit(1666, 100, 4);
      expect_out("t1_h2", 2, 3332, 3532, 4, 100, 0, 0, 1, mcx(4));
      hit(1666, 100, 6);
      expect_out("t1_h3", 3, 4998, 5298, 6, 100, 0, 1, 0, mcx(6));
      hit(50, 50, 9);
      expect_out("t1_after_done", 3, 4998, 5298, 6, 100, 0, 1, 0, mcx(6));

      // 2: five misses in Normal mode fail the song
      drive(1'b1, 1'b0, 2'b00, 10, 1'b0, 0, 0, 0);
      expect_out("t2_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(0, 0, 0); expect_out("t2_m1", 1, 0, 0, 0, 80, 0, 0, 1, 0);
      hit(0, 0, 0); expect_out("t2_m2", 2, 0, 0, 0, 60, 0, 0, 1, 0);
      hit(0, 0, 0); expect_out("t2_m3", 3, 0, 0, 0, 40, 0, 0, 1, 0);
      hit(0, 0, 0); expect_out("t2_m4", 4, 0, 0, 0, 20, 0, 0, 1, 0);
      hit(0, 0, 0); expect_out("t2_m5", 5, 0, 0, 0, 0, 1, 0, 0, 0);
      hit(5, 0, 1); expect_out("t2_drop", 5, 0, 0, 0, 0, 1, 0, 0, 0);

      // 3: No Fail mode keeps playing at hp 0, then recovers to done
      drive(1'b1, 1'b0, 2'b01, 10, 1'b0, 0, 0, 0);
      expect_out("t3_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         hit(0, 0, 0);
         expect_out($sformatf("t3_m%0d", i), i, 0, 0, 0, 8'(100 - 20 * i), 0, 0, 1, 0);
      end
      for (int i = 1; i <= 5; i++) begin
         hit(10, 0, i);
         expect_out($sformatf("t3_h%0d", i), 5 + i, 10 * i, 10 * i, i, 8'(2 * i), 0,
                    (i == 5), (i != 5), mcx(i));
      end

      // 4: saturation of both sums
      drive(1'b1, 1'b0, 2'b00, 2, 1'b0, 0, 0, 0);
      expect_out("t4_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(BIG, BIG, 0); expect_out("t4_n1", 1, BIG, SAT, 0, 100, 0, 0, 1, 0);
      hit(BIG, BIG, 0); expect_out("t4_n2", 2, SAT, SAT, 0, 100, 0, 1, 0, 0);

      // 5: start with hit in same cycle, abort+start, dropped note in IDLE, empty song
      drive(1'b1, 1'b0, 2'b00, 4, 1'b0, 0, 0, 0);
      expect_out("t5_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(100, 0, 1); expect_out("t5_h1", 1, 100, 100, 1, 100, 0, 0, 1, mcx(1));
      drive(1'b1, 1'b0, 2'b00, 4, 1'b1, 500, 0, 7);
      expect_out("t5_start_hit", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(30, 0, 2); expect_out("t5_h2", 1, 30, 30, 2, 100, 0, 0, 1, mcx(2));
      drive(1'b1, 1'b1, 2'b00, 4, 1'b0, 0, 0, 0);
      expect_out("t5_abort_start", 1, 30, 30, 2, 100, 0, 0, 0, mcx(2));
      hit(40, 0, 3); expect_out("t5_idle_drop", 1, 30, 30, 2, 100, 0, 0, 0, mcx(2));
      drive(1'b1, 1'b0, 2'b00, 0, 1'b0, 0, 0, 0);
      expect_out("t5_zero_song", 0, 0, 0, 0, 100, 0, 1, 0, 0);

      // 6: max combo tracking, then abort holds values
      drive(1'b1, 1'b0, 2'b00, 8, 1'b0, 0, 0, 0);
      expect_out("t6_start", 0, 0, 0, 0, 100, 0, 0, 1, 0);
      hit(10, 1, 5); expect_out("t6_c5", 1, 10, 11, 5, 100, 0, 0, 1, mcx(5));
      hit(10, 1, 9); expect_out("t6_c9", 2, 20, 22, 9, 100, 0, 0, 1, mcx(9));
      hit(10, 1, 0); expect_out("t6_c0", 3, 30, 33, 0, 100, 0, 0, 1, mcx(9));
      hit(10, 1, 3); expect_out("t6_c3", 4, 40, 44, 3, 100, 0, 0, 1, mcx(9));
      drive(1'b0, 1'b1, 2'b00, 8, 1'b0, 0, 0, 0);
      expect_out("t6_abort", 4, 40, 44, 3, 100, 0, 0, 0, mcx(9));

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
